store_wb_buffer: RTL and testbench
==================================

// Module: store_wb_buffer
// PURPOSE
//  Retired-store write buffer; consumes the SQ's per-cycle retire bundle (up to 3 stores) and drains to dcache.
//  Queues them in program order and drains one store per dcache req/ack handshake.
//  Forwards buffered bytes to loads, since retired stores are no longer visible in the SQ.
// PARAMETERS
//  WB_DEPTH  8     entries; power of 2, >=4
//  XLEN      32    data/address width (from sys_defs)
// PORTS
//  clock          in   1        single clock; all state updates on posedge
//  reset          in   1        synchronous, active-high
//  sq_wb          in   3xSQ_ENTRY_PACKET  retiring stores; [2] oldest; .ready=1 marks valid
//  wb_free        out  $clog2(WB_DEPTH)+1  free entries (registered count; SQ retire gating)
//  wb_empty       out  1        no valid entries and FSM IDLE
//  dc_req_valid   out  1        store request to dcache
//  dc_req_addr    out  XLEN     word-aligned address ([1:0]=0)
//  dc_req_data    out  XLEN     store data
//  dc_req_bytes   out  4        byte enables
//  dc_req_ack     in   1        dcache accepted current request
//  ld_addr        in   XLEN     load lookup address (word compare on [XLEN-1:2])
//  ld_fwd_bytes   out  4        bytes supplied by buffer
//  ld_fwd_data    out  XLEN     forwarded bytes; unsupplied bytes 0
// BEHAVIOUR
//  Reset: all entries invalid, head=tail=0, count=0, FSM IDLE.
//   Reset values: wb_free=WB_DEPTH, wb_empty=1, dc_req_valid=0, dc_req_*=0, ld_fwd_*=0.
//  Enqueue: valid sq_wb entries are contiguous from [2]; written at tail, tail+1, tail+2 in order [2],[1],[0].
//   Pointers wrap mod WB_DEPTH. Invalid entries in the bundle are ignored.
//  Credit: enqueued count <= wb_free of the same cycle (pre-pop); a same-cycle pop gives no extra credit.
//   Violation is a protocol error: assertion fires; excess stores are dropped.
//  FSM IDLE->SEND when next count>0; SEND->IDLE on ack when next count==0; otherwise stay SEND.
//   dc_req_valid = (state==SEND); dc_req_* driven from head entry.
//   Request fields are held stable until ack.
//  Latency: store enqueued at edge t into an empty, IDLE buffer -> dc_req_valid=1 from edge t+1.
//  Pop: on dc_req_ack with dc_req_valid=1 -> head invalidated, head++, count--.
//   Ack while valid=0 is ignored.
//  Simultaneous enqueue+pop: count_next = count + n_enq - pop.
//   Full buffer (wb_free=0): a pop still occurs; enqueue is 0 by credit.
//  Back-to-back acks drain one entry per cycle; the next head appears the cycle after an ack.
//  Forwarding (combinational): per byte, select the youngest valid entry, including the in-flight head, with matching word address and that byte enabled.
//   Entries enqueuing this cycle are not visible until next cycle.
//  Reset mid-operation: the pending request is abandoned; dc_req_valid=0 the cycle after reset.
//   Acks arriving during reset are ignored.
// CONFIGURATION
//  WB_COALESCE_EN defined:
//   An incoming store merges into the youngest valid entry when all of: same word address; not (head AND state==SEND).
//   Merge: usebytes OR'd; data bytes overwritten where incoming usebytes=1; no slot consumed.
//   Stores within one bundle also merge sequentially ([2] then [1] then [0]).
//   Credit rule unchanged (worst case, no merge).
//  WB_COALESCE_EN undefined: every valid store takes its own slot.
// STRUCTURE
//  Shared package (sys_defs): WB_ENTRY_PACKET {valid, usebytes[3:0], waddr[XLEN-1:2], data}.
//   Also WB_DEPTH and the WB_IDLE/WB_SEND state enum. SQ_ENTRY_PACKET is reused unchanged.
//  Sub-module wb_byte_fwd: per-byte youngest-first priority select over entries, ordered from tail backward.
//   Instantiated once; contains four priority selectors.
// TESTING
//  1 Reset, then one store {addr=0x100,data=0xAABBCCDD,bytes=1111} -> dc_req_valid next cycle, addr 0x100; ack -> wb_empty=1.
//  2 Three stores in one bundle (0x10,0x14,0x18), ack held low 5 cycles -> request stays 0x10, stable; acks every cycle -> order 0x10,0x14,0x18.
//  3 Fill 8 entries, no ack -> wb_free=0; ack plus zero enqueue -> wb_free=1 next cycle; wrap: 12 stores total drain in order.
//  4 Two stores to 0x40: bytes 0011 data 0x1111, then bytes 0110 data 0x2222_2200 -> ld_addr 0x40 gives ld_fwd_bytes=0111, data 0x0022_2211.
//  5 Assert reset while in SEND with 3 entries -> next cycle dc_req_valid=0, wb_free=8; a late ack is ignored.
//  6 WB_COALESCE_EN: two non-head stores to 0x80 (bytes 0001, 1000) -> one entry with bytes 1001; without the macro -> two entries.

Source files
------------

// File: rtl/store_wb_buffer_pkg.sv
// Shared definitions for the retired-store write buffer.
// Holds the buffer geometry, the SQ retire packet, the buffer entry packet,
// the drain FSM state encodings and a byte-enable to bit-mask helper.
package store_wb_buffer_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned WB_DEPTH = 8;
  localparam int unsigned WB_PTR_W = $clog2(WB_DEPTH);
  localparam int unsigned WB_CNT_W = WB_PTR_W + 1;

  // Drain FSM encodings
  localparam logic [0:0] WB_IDLE = 1'b0;
  localparam logic [0:0] WB_SEND = 1'b1;

  // One retiring store from the SQ; ready=1 marks the slot valid
  typedef struct packed {
    logic            ready;
    logic [3:0]      usebytes;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } SQ_ENTRY_PACKET;

  // One buffered store, tracked by word address
  typedef struct packed {
    logic            valid;
    logic [3:0]      usebytes;
    logic [XLEN-1:2] waddr;
    logic [XLEN-1:0] data;
  } WB_ENTRY_PACKET;

  // Expand 4 byte enables into a XLEN-bit data mask
  function automatic logic [XLEN-1:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/store_wb_buffer_byte_fwd.sv
// Load forwarding unit (wb_byte_fwd): for each of the four bytes, picks the
// youngest valid entry whose word address matches and that enables the byte.
// Ports:
//   ents_i      all buffer entries (registered state)
//   tail_i      next write slot; tail_i-1 is the youngest entry
//   waddr_i     load word address
//   fwd_bytes_o bytes supplied by the buffer
//   fwd_data_o  forwarded data, unsupplied bytes zero
module store_wb_buffer_byte_fwd
  import store_wb_buffer_pkg::*;
(
  input  WB_ENTRY_PACKET [WB_DEPTH-1:0] ents_i,
  input  logic [WB_PTR_W-1:0]           tail_i,
  input  logic [XLEN-1:2]               waddr_i,
  output logic [3:0]                    fwd_bytes_o,
  output logic [XLEN-1:0]               fwd_data_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    logic                hit;
    logic [7:0]          sel;
    logic [WB_PTR_W-1:0] idx;

    // Walk from the youngest entry backward; first match wins
    always_comb begin
      hit = 1'b0;
      sel = '0;
      idx = '0;
      for (int i = 0; i < int'(WB_DEPTH); i++) begin
        idx = tail_i - WB_PTR_W'(i + 1);
        if (!hit && ents_i[idx].valid && ents_i[idx].usebytes[b] &&
            (ents_i[idx].waddr == waddr_i)) begin
          hit = 1'b1;
          sel = ents_i[idx].data[8*b +: 8];
        end
      end
    end

    assign fwd_bytes_o[b]       = hit;
    assign fwd_data_o[8*b +: 8] = sel;
  end

endmodule

// File: rtl/store_wb_buffer.sv
// Retired-store write buffer. Accepts up to three retiring stores per cycle
// in program order ([2] oldest), drains one store per dcache req/ack
// handshake and forwards buffered bytes to loads.
// Optional feature: define WB_COALESCE_EN to merge an incoming store into the
// youngest entry when it targets the same word and that entry is not the
// in-flight head.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   sq_wb               retire bundle from the SQ
//   wb_free             free entries (credit for SQ retirement)
//   wb_empty            no entries and FSM idle
//   dc_req_valid/addr/data/bytes, dc_req_ack   dcache store handshake
//   ld_addr             load lookup address
//   ld_fwd_bytes/data   forwarded bytes (combinational)
module store_wb_buffer
  import store_wb_buffer_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  SQ_ENTRY_PACKET [2:0]   sq_wb,
  output logic [WB_CNT_W-1:0]    wb_free,
  output logic                   wb_empty,
  output logic                   dc_req_valid,
  output logic [XLEN-1:0]        dc_req_addr,
  output logic [XLEN-1:0]        dc_req_data,
  output logic [3:0]             dc_req_bytes,
  input  logic                   dc_req_ack,
  input  logic [XLEN-1:0]        ld_addr,
  output logic [3:0]             ld_fwd_bytes,
  output logic [XLEN-1:0]        ld_fwd_data
);

  WB_ENTRY_PACKET [WB_DEPTH-1:0] ent_q, ent_d;
  logic [WB_PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [WB_CNT_W-1:0]           count_q, count_d, free_q, free_d;
  logic [0:0]                    state_q, state_d;

  logic [1:0]          n_valid;
  logic [WB_CNT_W-1:0] n_acc, n_alloc;
  logic                pop, merge;
  SQ_ENTRY_PACKET      st;
`ifdef WB_COALESCE_EN
  logic [WB_PTR_W-1:0] yidx;
`endif

  // Valid stores are contiguous from the oldest slot
  assign n_valid = sq_wb[2].ready ? (sq_wb[1].ready ? (sq_wb[0].ready ? 2'd3 : 2'd2) : 2'd1) : 2'd0;
  // Stores beyond the credit are dropped
  assign n_acc   = (WB_CNT_W'(n_valid) > free_q) ? free_q : WB_CNT_W'(n_valid);
  assign pop     = (state_q == WB_SEND) && dc_req_ack;

  // Next-state: pop head first, then enqueue/merge the bundle in order
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;
    n_alloc = '0;
    st      = '0;
    merge   = 1'b0;
`ifdef WB_COALESCE_EN
    yidx    = '0;
`endif

    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + WB_PTR_W'(1);
    end

    for (int i = 0; i < 3; i++) begin
      if (WB_CNT_W'(i) < n_acc) begin
        st = sq_wb[2'(2 - i)];
`ifdef WB_COALESCE_EN
        // Youngest entry may be one written earlier in this same bundle
        yidx  = tail_d - WB_PTR_W'(1);
        merge = ent_d[yidx].valid && (ent_d[yidx].waddr == st.addr[XLEN-1:2]) &&
                !((yidx == head_q) && (state_q == WB_SEND));
        if (merge) begin
          ent_d[yidx].usebytes = ent_d[yidx].usebytes | st.usebytes;
          ent_d[yidx].data     = (ent_d[yidx].data & ~byte_mask(st.usebytes)) |
                                 (st.data & byte_mask(st.usebytes));
        end
`else
        merge = 1'b0;
`endif
        if (!merge) begin
          ent_d[tail_d].valid    = 1'b1;
          ent_d[tail_d].usebytes = st.usebytes;
          ent_d[tail_d].waddr    = st.addr[XLEN-1:2];
          ent_d[tail_d].data     = st.data;
          tail_d                 = tail_d + WB_PTR_W'(1);
          n_alloc                = n_alloc + WB_CNT_W'(1);
        end
      end
    end

    count_d = count_q + n_alloc - WB_CNT_W'(pop);
    free_d  = WB_CNT_W'(WB_DEPTH) - count_d;

    case (state_q)
      WB_IDLE: if (count_d != '0) state_d = WB_SEND;
      WB_SEND: if (pop && (count_d == '0)) state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= WB_CNT_W'(WB_DEPTH);
      state_q <= WB_IDLE;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
      state_q <= state_d;
    end
  end

  // Protocol checks on the retire bundle
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (WB_CNT_W'(n_valid) <= free_q);
      assert (!(sq_wb[1].ready && !sq_wb[2].ready) && !(sq_wb[0].ready && !sq_wb[1].ready));
    end
  end

  // Request fields come from the head entry and are zero while idle
  assign wb_free      = free_q;
  assign wb_empty     = (count_q == '0) && (state_q == WB_IDLE);
  assign dc_req_valid = (state_q == WB_SEND);
  assign dc_req_addr  = dc_req_valid ? {ent_q[head_q].waddr, 2'b00} : '0;
  assign dc_req_data  = dc_req_valid ? ent_q[head_q].data : '0;
  assign dc_req_bytes = dc_req_valid ? ent_q[head_q].usebytes : '0;

  store_wb_buffer_byte_fwd u_fwd (
    .ents_i      (ent_q),
    .tail_i      (tail_q),
    .waddr_i     (ld_addr[XLEN-1:2]),
    .fwd_bytes_o (ld_fwd_bytes),
    .fwd_data_o  (ld_fwd_data)
  );

  // Byte offsets are not needed for word-granular tracking
  logic unused_lo;
  assign unused_lo = ^{ld_addr[1:0], sq_wb[0].addr[1:0], sq_wb[1].addr[1:0], sq_wb[2].addr[1:0]};

endmodule

// File: tb/tb_store_wb_buffer.sv
module tb_store_wb_buffer;
  import store_wb_buffer_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  SQ_ENTRY_PACKET [2:0] sq_wb;
  logic [WB_CNT_W-1:0]  wb_free;
  logic                 wb_empty;
  logic                 dc_req_valid;
  logic [XLEN-1:0]      dc_req_addr;
  logic [XLEN-1:0]      dc_req_data;
  logic [3:0]           dc_req_bytes;
  logic                 dc_req_ack;
  logic [XLEN-1:0]      ld_addr;
  logic [3:0]           ld_fwd_bytes;
  logic [XLEN-1:0]      ld_fwd_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bytes;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [31:0] data;
    logic [3:0]  bytes;
    logic        ack;
    logic [3:0]  exp_free;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_empty;
  } vec_t;

  store_wb_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .sq_wb        (sq_wb),
    .wb_free      (wb_free),
    .wb_empty     (wb_empty),
    .dc_req_valid (dc_req_valid),
    .dc_req_addr  (dc_req_addr),
    .dc_req_data  (dc_req_data),
    .dc_req_bytes (dc_req_bytes),
    .dc_req_ack   (dc_req_ack),
    .ld_addr      (ld_addr),
    .ld_fwd_bytes (ld_fwd_bytes),
    .ld_fwd_data  (ld_fwd_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive bundle + ack, score an accepted request, advance
  task automatic cycle(input int n, input logic [31:0] base, input logic [31:0] data,
                       input logic [3:0] bytes, input logic ack, input bit push);
    exp_t e;
    sq_wb = '0;
    for (int k = 0; k < n; k++) begin
      sq_wb[2'(2 - k)].ready    = 1'b1;
      sq_wb[2'(2 - k)].usebytes = bytes;
      sq_wb[2'(2 - k)].addr     = base + 32'(4 * k);
      sq_wb[2'(2 - k)].data     = data + 32'(k);
      if (push) begin
        e.addr  = (base + 32'(4 * k)) & ~32'h3;
        e.data  = data + 32'(k);
        e.bytes = bytes;
        sb.push_back(e);
      end
    end
    dc_req_ack = ack;
    #1;
    if (ack && dc_req_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: request 0x%08h with nothing expected", dc_req_addr);
      end else begin
        e = sb.pop_front();
        chk("req_addr", dc_req_addr, e.addr);
        chk("req_data", dc_req_data, e.data);
        chk("req_bytes", 32'(dc_req_bytes), 32'(e.bytes));
      end
    end
    @(posedge clock);
    #1;
    sq_wb      = '0;
    dc_req_ack = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && !wb_empty; i++) cycle(0, 0, 0, 4'h0, 1'b1, 1'b0);
    chk({tag, "_empty"}, 32'(wb_empty), 32'd1);
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    sq_wb      = '0;
    dc_req_ack = 1'b0;
    ld_addr    = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    vec_t vt [11];
    exp_t e;

    // Tests 1 and 2: single store, then a 3-store bundle held then drained
    vt[0]  = '{1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b0, 4'd7, 1'b1, 32'h100, 1'b0};
    vt[1]  = '{0, 32'h0,   32'h0,        4'h0, 1'b1, 4'd8, 1'b0, 32'h0,   1'b1};
    vt[2]  = '{3, 32'h10,  32'h1000,     4'hF, 1'b0, 4'd5, 1'b1, 32'h10,  1'b0};
    for (int r = 3; r < 8; r++)
      vt[r] = '{0, 32'h0,  32'h0,        4'h0, 1'b0, 4'd5, 1'b1, 32'h10,  1'b0};
    vt[8]  = '{0, 32'h0,   32'h0,        4'h0, 1'b1, 4'd6, 1'b1, 32'h14,  1'b0};
    vt[9]  = '{0, 32'h0,   32'h0,        4'h0, 1'b1, 4'd7, 1'b1, 32'h18,  1'b0};
    vt[10] = '{0, 32'h0,   32'h0,        4'h0, 1'b1, 4'd8, 1'b0, 32'h0,   1'b1};

    do_reset();
    chk("rst_free", 32'(wb_free), 32'd8);
    chk("rst_empty", 32'(wb_empty), 32'd1);
    chk("rst_valid", 32'(dc_req_valid), 32'd0);
    chk("rst_addr", dc_req_addr, 32'h0);
    chk("rst_data", dc_req_data, 32'h0);
    chk("rst_bytes", 32'(dc_req_bytes), 32'h0);
    chk("rst_fwd_bytes", 32'(ld_fwd_bytes), 32'h0);
    chk("rst_fwd_data", ld_fwd_data, 32'h0);

    for (int r = 0; r < 11; r++) begin
      cycle(vt[r].n, vt[r].base, vt[r].data, vt[r].bytes, vt[r].ack, 1'b1);
      chk($sformatf("v%0d_free", r), 32'(wb_free), 32'(vt[r].exp_free));
      chk($sformatf("v%0d_valid", r), 32'(dc_req_valid), 32'(vt[r].exp_valid));
      chk($sformatf("v%0d_addr", r), dc_req_addr, vt[r].exp_addr);
      chk($sformatf("v%0d_empty", r), 32'(wb_empty), 32'(vt[r].exp_empty));
    end

    // Test 3: fill, free one slot, then wrap while draining
    cycle(3, 32'h500, 32'h5000, 4'hF, 1'b0, 1'b1);
    cycle(3, 32'h50C, 32'h5003, 4'hF, 1'b0, 1'b1);
    cycle(2, 32'h518, 32'h5006, 4'hF, 1'b0, 1'b1);
    chk("full_free", 32'(wb_free), 32'd0);
    chk("full_head", dc_req_addr, 32'h500);
    cycle(0, 0, 0, 4'h0, 1'b1, 1'b0);
    chk("full_pop_free", 32'(wb_free), 32'd1);
    for (int j = 0; j < 4; j++) begin
      cycle(1, 32'h520 + 32'(4 * j), 32'h5008 + 32'(j), 4'hF, 1'b1, 1'b1);
      chk($sformatf("wrap%0d_free", j), 32'(wb_free), 32'd1);
    end
    drain("wrap");

    // Test 4: byte forwarding, youngest wins, same-cycle store invisible
    ld_addr = 32'h40;
    cycle(1, 32'h40, 32'h0000_1111, 4'b0011, 1'b0, 1'b1);
    chk("fwd1_bytes", 32'(ld_fwd_bytes), 32'h3);
    chk("fwd1_data", ld_fwd_data, 32'h0000_1111);
    sq_wb             = '0;
    sq_wb[2].ready    = 1'b1;
    sq_wb[2].usebytes = 4'b0110;
    sq_wb[2].addr     = 32'h40;
    sq_wb[2].data     = 32'h2222_2200;
    #1;
    chk("fwd_inflight_bytes", 32'(ld_fwd_bytes), 32'h3);
    chk("fwd_inflight_data", ld_fwd_data, 32'h0000_1111);
    @(posedge clock);
    #1;
    sq_wb   = '0;
    e.addr  = 32'h40;
    e.data  = 32'h2222_2200;
    e.bytes = 4'b0110;
    sb.push_back(e);
    chk("fwd2_bytes", 32'(ld_fwd_bytes), 32'h7);
    chk("fwd2_data", ld_fwd_data, 32'h0022_2211);
    ld_addr = 32'h43;
    #1;
    chk("fwd_same_word", ld_fwd_data, 32'h0022_2211);
    ld_addr = 32'h44;
    #1;
    chk("fwd_miss_bytes", 32'(ld_fwd_bytes), 32'h0);
    drain("fwd");
    ld_addr = 32'h40;
    #1;
    chk("fwd_after_drain", 32'(ld_fwd_bytes), 32'h0);

    // Test 5: reset while sending; acks during and after reset ignored
    cycle(3, 32'h300, 32'h3000, 4'hF, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(dc_req_valid), 32'd1);
    chk("pre_rst_free", 32'(wb_free), 32'd5);
    reset      = 1'b1;
    dc_req_ack = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_valid", 32'(dc_req_valid), 32'd0);
    chk("midrst_free", 32'(wb_free), 32'd8);
    chk("midrst_empty", 32'(wb_empty), 32'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    dc_req_ack = 1'b0;
    chk("late_ack_valid", 32'(dc_req_valid), 32'd0);
    chk("late_ack_free", 32'(wb_free), 32'd8);
    sb.delete();

    // Test 6: two non-head stores to the same word
    cycle(1, 32'h200, 32'h2000, 4'hF, 1'b0, 1'b1);
    cycle(1, 32'h80, 32'h0000_00AA, 4'b0001, 1'b0, 1'b0);
    cycle(1, 32'h80, 32'hBB00_0000, 4'b1000, 1'b0, 1'b0);
`ifdef WB_COALESCE_EN
    chk("coal_free", 32'(wb_free), 32'd6);
    e.addr = 32'h80; e.data = 32'hBB00_00AA; e.bytes = 4'b1001;
    sb.push_back(e);
`else
    chk("coal_free", 32'(wb_free), 32'd5);
    e.addr = 32'h80; e.data = 32'h0000_00AA; e.bytes = 4'b0001;
    sb.push_back(e);
    e.addr = 32'h80; e.data = 32'hBB00_0000; e.bytes = 4'b1000;
    sb.push_back(e);
`endif
    ld_addr = 32'h80;
    #1;
    chk("coal_fwd_bytes", 32'(ld_fwd_bytes), 32'h9);
    chk("coal_fwd_data", ld_fwd_data, 32'hBB00_00AA);
    drain("coal");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
